// File: rtl/div_float_pkg.sv
// rtl/div_float_pkg.sv - shared constants, flag indices and FSM encoding for the divider front end
package div_float_pkg;

    function automatic int exp_width(input int float_width);
        return (float_width == 32) ? 8 : 11;
    endfunction

    function automatic int fraction_width(input int float_width);
        return (float_width == 32) ? 23 : 52;
    endfunction

    // Cycles from the divider sampling start to done; the watchdog must exceed this.
    function automatic int div_latency(input int float_width);
        return fraction_width(float_width) + 4;
    endfunction

    // Bit positions inside the divider's 6-bit flag bus.
    localparam int FLAG_DONE      = 0;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_NAN       = 4;
    localparam int FLAG_DBZ       = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/div_float_sequencer_if.sv
// rtl/div_float_sequencer_if.sv - request, divider and response signal bundle
interface div_float_sequencer_if #(
    parameter int FLOAT_WIDTH = 64,
    parameter int TAG_WIDTH   = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [FLOAT_WIDTH-1:0] req_op1;
    logic [FLOAT_WIDTH-1:0] req_op2;
    logic [TAG_WIDTH-1:0]   req_tag;

    logic                   div_start;
    logic [FLOAT_WIDTH-1:0] div_op1;
    logic [FLOAT_WIDTH-1:0] div_op2;
    logic [FLOAT_WIDTH-1:0] div_out;
    logic [5:0]             div_flags;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [FLOAT_WIDTH-1:0] rsp_result;
    logic [4:0]             rsp_flags;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic                   rsp_timeout;
    logic                   busy;

    modport slave (
        input  req_valid, req_op1, req_op2, req_tag, div_out, div_flags, rsp_ready,
        output req_ready, div_start, div_op1, div_op2,
               rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_op1, req_op2, req_tag, div_out, div_flags, rsp_ready,
        input  req_ready, div_start, div_op1, div_op2,
               rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout, busy
    );
endinterface

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - synchronous request FIFO with wrap-bit pointers
module div_req_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointer difference is the occupancy; the extra bit disambiguates full from empty.
    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/div_float_sequencer.sv
// rtl/div_float_sequencer.sv - queues divide requests, runs the divider start/done protocol, returns tagged responses
module div_float_sequencer
    import div_float_pkg::*;
#(
    parameter int FLOAT_WIDTH    = 64,
    parameter int TAG_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic clk,
    input  logic rst_n,
    div_float_sequencer_if.slave bus
);
    localparam int DW   = 2*FLOAT_WIDTH + TAG_WIDTH;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES <= div_latency(FLOAT_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed the divider latency");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    seq_state_t             state;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [DW-1:0]          fifo_rdata;
    logic                   fifo_pop;
    logic [FLOAT_WIDTH-1:0] head_op1;
    logic [FLOAT_WIDTH-1:0] head_op2;
    logic [TAG_WIDTH-1:0]   head_tag;

    logic                   start_q;
    logic [FLOAT_WIDTH-1:0] op1_q;
    logic [FLOAT_WIDTH-1:0] op2_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [WD_W-1:0]        watchdog;
    logic                   rsp_valid_q;
    logic [FLOAT_WIDTH-1:0] rsp_result_q;
    logic [4:0]             rsp_flags_q;
    logic [TAG_WIDTH-1:0]   rsp_tag_q;
    logic                   rsp_timeout_q;

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign {head_op1, head_op2, head_tag} = fifo_rdata;

    div_req_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_valid && !fifo_full),
        .wdata ({bus.req_op1, bus.req_op2, bus.req_tag}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            start_q       <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            tag_q         <= '0;
            watchdog      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op1_q   <= head_op1;
                        op2_q   <= head_op2;
                        tag_q   <= head_tag;
                        start_q <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    start_q  <= 1'b0;
                    watchdog <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.div_flags[FLAG_DONE]) begin
                        rsp_result_q  <= bus.div_out;
                        rsp_flags_q   <= bus.div_flags[FLAG_DBZ:FLAG_ZERO];
                        rsp_tag_q     <= tag_q;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state         <= ST_RESP;
                    end else if (watchdog == WD_LAST) begin
                        // Divider never reported done: return a zeroed, flagged response.
                        rsp_result_q  <= '0;
                        rsp_flags_q   <= '0;
                        rsp_tag_q     <= tag_q;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.div_start   = start_q;
    assign bus.div_op1     = op1_q;
    assign bus.div_op2     = op2_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = (state != ST_IDLE) || (fifo_count != '0);

endmodule
